// File: rtl/spi_ram_ctrl.sv
// Command-decoding byte RAM behind an SPI slave: the write/read address and data
// commands arrive as 10-bit words, and read-back bytes are handed back for MISO shifting.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid
);

    typedef enum logic [1:0] {
        CMD_WR_ADDR = 2'b00,
        CMD_WR_DATA = 2'b01,
        CMD_RD_ADDR = 2'b10,
        CMD_RD_DATA = 2'b11
    } cmd_t;

    // One extra bit so that a full 2**ADDR_SIZE depth can be compared against.
    localparam logic [ADDR_SIZE:0] DEPTH_W = (ADDR_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDR_SIZE:0] LAST_W  = (ADDR_SIZE + 1)'(MEM_DEPTH - 1);

    logic [7:0]           mem [MEM_DEPTH];

    logic                 rx_valid_d_reg;
    logic [ADDR_SIZE-1:0] wr_addr_reg, wr_addr_next;
    logic [ADDR_SIZE-1:0] rd_addr_reg, rd_addr_next;
    logic                 tx_valid_reg, tx_valid_next;
    logic [7:0]           tx_data_reg;

    cmd_t                 cmd;
    logic                 accept;
    logic                 wr_in_range;
    logic                 rd_in_range;
    logic                 mem_we;
    logic                 rd_en;

    assign cmd         = cmd_t'(rx_data[9:8]);
    assign accept      = rx_valid && !rx_valid_d_reg;
    assign wr_in_range = {1'b0, wr_addr_reg} < DEPTH_W;
    assign rd_in_range = {1'b0, rd_addr_reg} < DEPTH_W;

    always_comb begin
        wr_addr_next  = wr_addr_reg;
        rd_addr_next  = rd_addr_reg;
        tx_valid_next = tx_valid_reg;
        mem_we        = 1'b0;
        rd_en         = 1'b0;
        if (accept) begin
            tx_valid_next = 1'b0;
            unique case (cmd)
                CMD_WR_ADDR: wr_addr_next = ADDR_SIZE'(rx_data[7:0]);
                CMD_WR_DATA: begin
                    mem_we       = wr_in_range;
                    wr_addr_next = ({1'b0, wr_addr_reg} == LAST_W) ? '0 : wr_addr_reg + 1'b1;
                end
                CMD_RD_ADDR: rd_addr_next = ADDR_SIZE'(rx_data[7:0]);
                CMD_RD_DATA: begin
                    rd_en         = 1'b1;
                    tx_valid_next = 1'b1;
                    rd_addr_next  = ({1'b0, rd_addr_reg} == LAST_W) ? '0 : rd_addr_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Control path; the read register is loaded only by RD_DATA so tx_data holds between reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_valid_d_reg <= 1'b0;
            wr_addr_reg    <= '0;
            rd_addr_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            tx_data_reg    <= 8'h00;
        end else begin
            rx_valid_d_reg <= rx_valid;
            wr_addr_reg    <= wr_addr_next;
            rd_addr_reg    <= rd_addr_next;
            tx_valid_reg   <= tx_valid_next;
            if (rd_en) begin
                tx_data_reg <= rd_in_range ? mem[rd_addr_reg] : 8'h00;
            end
        end
    end

    // Array contents survive reset; only the write itself is blocked while rst is high.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem[wr_addr_reg] <= rx_data[7:0];
        end
    end

    assign tx_data  = tx_data_reg;
    assign tx_valid = tx_valid_reg;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: a vector table of commands with expected read-back,
// followed by hand-written sequences for held rx_valid, long tx hold and reset cases.
module tb_spi_ram_ctrl;

    logic       clk;
    logic       rst;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int n_cmp;
    int n_bad;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       do_rst;
        logic [1:0] cmd;
        logic [7:0] payload;
        logic       exp_valid;
        logic       chk_data;
        logic [7:0] exp_data;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs [NVEC];
    int   nv;

    task automatic add(input logic r, input logic [1:0] c, input logic [7:0] p,
                       input logic ev, input logic cd, input logic [7:0] ed);
        vecs[nv] = '{do_rst: r, cmd: c, payload: p, exp_valid: ev, chk_data: cd, exp_data: ed};
        nv++;
    endtask

    task automatic check_valid(input string name, input logic exp);
        n_cmp++;
        if (tx_valid !== exp) begin
            n_bad++;
            $display("FAIL %s: tx_valid=%b required %b", name, tx_valid, exp);
        end else begin
            $display("ok   %s: tx_valid=%b", name, tx_valid);
        end
    endtask

    task automatic check_data(input string name, input logic [7:0] exp);
        n_cmp++;
        if (tx_data !== exp) begin
            n_bad++;
            $display("FAIL %s: tx_data=%h required %h", name, tx_data, exp);
        end else begin
            $display("ok   %s: tx_data=%h", name, tx_data);
        end
    endtask

    // One accepted command: rx_valid high for one edge, then low for one edge.
    task automatic send(input logic [1:0] c, input logic [7:0] p);
        @(negedge clk);
        rx_data  = {c, p};
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_rst();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        nv       = 0;
        rst      = 1'b1;
        rx_data  = '0;
        rx_valid = 1'b0;

        add(1, 2'b00, 8'h00, 0, 1, 8'h00);
        add(0, 2'b10, 8'h00, 0, 0, 8'h00);
        add(0, 2'b11, 8'h00, 1, 0, 8'h00);
        add(0, 2'b00, 8'h10, 0, 0, 8'h00);
        add(0, 2'b01, 8'hA5, 0, 0, 8'h00);
        add(0, 2'b01, 8'h3C, 0, 0, 8'h00);
        add(0, 2'b10, 8'h10, 0, 0, 8'h00);
        add(0, 2'b11, 8'h00, 1, 1, 8'hA5);
        add(0, 2'b11, 8'hEE, 1, 1, 8'h3C);
        add(0, 2'b00, 8'hFF, 0, 0, 8'h00);
        add(0, 2'b01, 8'h11, 0, 0, 8'h00);
        add(0, 2'b01, 8'h22, 0, 0, 8'h00);
        add(0, 2'b10, 8'hFF, 0, 0, 8'h00);
        add(0, 2'b11, 8'h00, 1, 1, 8'h11);
        add(0, 2'b11, 8'h00, 1, 1, 8'h22);
        add(0, 2'b00, 8'h40, 0, 0, 8'h00);
        add(0, 2'b01, 8'h5A, 0, 0, 8'h00);
        add(0, 2'b10, 8'h40, 0, 0, 8'h00);
        add(0, 2'b11, 8'h00, 1, 1, 8'h5A);

        repeat (2) @(negedge clk);
        for (int i = 0; i < nv; i++) begin
            if (vecs[i].do_rst) pulse_rst();
            else send(vecs[i].cmd, vecs[i].payload);
            check_valid($sformatf("vec%0d", i), vecs[i].exp_valid);
            if (vecs[i].chk_data) check_data($sformatf("vec%0d", i), vecs[i].exp_data);
        end

        // tx byte from the last vector must hold while rx_valid stays low.
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check_valid($sformatf("hold%0d", k), 1'b1);
            check_data($sformatf("hold%0d", k), 8'h5A);
        end
        send(2'b00, 8'h50);
        check_valid("wr_addr_drops_valid", 1'b0);

        // rx_valid held for 5 cycles must produce a single write.
        send(2'b00, 8'h32);
        send(2'b01, 8'h99);
        send(2'b00, 8'h30);
        @(negedge clk);
        rx_data  = {2'b01, 8'h44};
        rx_valid = 1'b1;
        repeat (5) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        send(2'b01, 8'h55);
        send(2'b10, 8'h30);
        send(2'b11, 8'h00);
        check_data("held_wr_30", 8'h44);
        send(2'b11, 8'h00);
        check_data("held_wr_31", 8'h55);
        send(2'b11, 8'h00);
        check_data("held_wr_32_intact", 8'h99);

        // Reset mid-sequence clears pointers and tx, keeps memory.
        send(2'b00, 8'h20);
        pulse_rst();
        @(negedge clk);
        check_valid("mid_rst_valid", 1'b0);
        check_data("mid_rst_data", 8'h00);
        send(2'b01, 8'h77);
        send(2'b01, 8'h88);
        send(2'b10, 8'h00);
        send(2'b11, 8'h00);
        check_data("post_rst_addr0", 8'h77);
        send(2'b10, 8'h10);
        send(2'b11, 8'h00);
        check_data("mem_preserved_10", 8'hA5);

        // RD_DATA held across reset release is accepted exactly once.
        @(negedge clk);
        rst      = 1'b1;
        rx_data  = {2'b11, 8'h00};
        rx_valid = 1'b1;
        repeat (2) @(negedge clk);
        check_valid("rst_held_valid", 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check_valid("rst_release_accept", 1'b1);
        check_data("rst_release_accept", 8'h77);
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        @(negedge clk);
        send(2'b11, 8'h00);
        check_data("rst_release_once", 8'h88);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
- Command-decoding single-port RAM that sits directly downstream of the SPI slave.
- Consumes the slave's 10-bit rx_data/rx_valid words.
- Executes write-address, write-data, read-address and read-data commands against an internal byte array.
- Returns read bytes to the slave on tx_data/tx_valid for MISO shifting.

Parameters:
- MEM_DEPTH, 256, number of 8-bit words in the array; MEM_DEPTH <= 2**ADDR_SIZE.
- ADDR_SIZE, 8, width of the internal write/read address pointers (loaded from rx_data[7:0]).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- rx_data  input  10  [9:8] command, [7:0] address or data payload.
- rx_valid  input  1  high while rx_data holds a complete word from the SPI slave.
- tx_data  output  8  read-back byte for the SPI slave.
- tx_valid  output  1  tx_data holds a valid read-back byte.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). rst is sampled only on posedge clk and has priority over every other event in that cycle.
- Reset values:
  - tx_data=8'h00, tx_valid=0.
  - wr_addr=0, rd_addr=0, rx_valid_d=0.
  - Memory contents are NOT cleared; they are undefined until written.
- Command acceptance:
  - A command is accepted at posedge N when rx_valid=1 and rx_valid_d=0 (rising-edge detect). rx_valid_d <= rx_valid every cycle.
  - rx_valid held high for several cycles therefore yields exactly one command.
  - rx_valid already high when rst deasserts is accepted once, on the first post-reset edge.
- Command decode on rx_data[9:8], all effects visible after posedge N:
  - 2'b00 WR_ADDR: wr_addr <= rx_data[7:0]; tx_valid <= 0.
  - 2'b01 WR_DATA:
    - mem[wr_addr] <= rx_data[7:0] if wr_addr < MEM_DEPTH; otherwise the write is dropped.
    - wr_addr <= wr_addr+1, wrapping to 0 after MEM_DEPTH-1.
    - tx_valid <= 0.
  - 2'b10 RD_ADDR: rd_addr <= rx_data[7:0]; tx_valid <= 0.
  - 2'b11 RD_DATA:
    - tx_data <= mem[rd_addr], or 8'h00 if rd_addr >= MEM_DEPTH.
    - tx_valid <= 1.
    - rd_addr <= rd_addr+1, wrapping to 0 after MEM_DEPTH-1.
    - rx_data[7:0] is ignored (dummy byte).
- Latency: RD_DATA accepted at edge N gives tx_data/tx_valid valid from edge N through the next accepted command.
- tx_valid hold:
  - tx_valid stays 1, and tx_data stays stable, until the next accepted command or reset.
  - This lets the SPI slave shift all 8 bits.
  - A following RD_DATA reloads tx_data and keeps tx_valid=1 with no low cycle.
- Pointer independence: wr_addr and rd_addr are separate registers; WR_* commands never modify rd_addr and vice versa.
- Hazard: WR_DATA to address A followed by any later RD_DATA at A returns the new value. There is no same-cycle read/write, since one command is accepted per edge.
- Reset mid-operation:
  - Pointers, tx_valid and tx_data are cleared in the next cycle.
  - Memory writes in the reset cycle are suppressed.
  - Memory contents written before reset are preserved.
- No states beyond the accept/decode path. The rising-edge detector and the two address pointers are the only sequential control.

Test Plan:
- Reset with rx_valid=0 -> tx_valid=0, tx_data=8'h00. A subsequent RD_ADDR 8'h00 then RD_DATA yields tx_valid=1 (data unchecked).
- WR_ADDR 8'h10, WR_DATA 8'hA5, WR_DATA 8'h3C, RD_ADDR 8'h10, RD_DATA, RD_DATA -> tx_data 8'hA5 then 8'h3C, tx_valid=1 after each edge, no low gap.
- WR_ADDR 8'hFF, WR_DATA 8'h11, WR_DATA 8'h22 (MEM_DEPTH=256) -> mem[255]=8'h11, mem[0]=8'h22. RD_ADDR 8'hFF, RD_DATA, RD_DATA return 8'h11, 8'h22.
- rx_valid held high 5 cycles with a WR_DATA word -> exactly one write, wr_addr advances by 1 only.
- RD_DATA returning 8'h5A, rx_valid held low 20 cycles -> tx_data=8'h5A, tx_valid=1 throughout. Next WR_ADDR -> tx_valid=0 after that edge.
- rst=1 asserted mid-sequence after WR_ADDR 8'h20 -> tx_valid=0, wr_addr=0. A WR_DATA 8'h77 then lands at address 0, confirmed by RD_ADDR 8'h00, RD_DATA returning 8'h77.
